// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB/SLT plus an iterative
// shift-add multiplier that stalls upstream through in_ready/busy.
module alu_exec_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             out_valid,
   output logic             busy
);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic {IDLE, MUL_RUN} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplr_q, mplr_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               out_valid_q, out_valid_d;

   logic [WIDTH-1:0]   alu_f;
   logic [WIDTH-1:0]   acc_sum;
   logic               accept;

   assign accept  = in_valid && !flush && (state_q == IDLE);
   assign acc_sum = acc_q + (mplr_q[0] ? mcand_q : '0);

   // Single-cycle function; MUL and the unused codes fall to zero here
   always_comb begin
      alu_f = '0;
      unique case (alu_control)
         OP_AND:  alu_f = src_a & src_b;
         OP_OR:   alu_f = src_a | src_b;
         OP_ADD:  alu_f = src_a + src_b;
         OP_SUB:  alu_f = src_a - src_b;
         OP_SLT:  alu_f = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         default: alu_f = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mcand_q     <= '0;
         mplr_q      <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         mplr_q      <= mplr_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Next-state: flush always returns to IDLE
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (accept && alu_control == OP_MUL) state_d = MUL_RUN;
            MUL_RUN: if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Datapath and registered-output next values
   always_comb begin
      mcand_d     = mcand_q;
      mplr_d      = mplr_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      zero_d      = zero_q;
      out_valid_d = 1'b0;
      if (!flush) begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  if (alu_control == OP_MUL) begin
                     mcand_d = src_a;
                     mplr_d  = src_b;
                     acc_d   = '0;
                     cnt_d   = CNT_W'(WIDTH - 1);
                  end else begin
                     result_d    = alu_f;
                     zero_d      = (alu_f == '0);
                     out_valid_d = 1'b1;
                  end
               end
            end
            MUL_RUN: begin
               acc_d   = acc_sum;
               mcand_d = mcand_q << 1;
               mplr_d  = mplr_q >> 1;
               cnt_d   = cnt_q - CNT_W'(1);
               if (cnt_q == '0) begin
                  result_d    = acc_sum;
                  zero_d      = (acc_sum == '0);
                  out_valid_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Ready/busy depend on state only
   always_comb begin
      in_ready = 1'b1;
      busy     = 1'b0;
      if (state_q == MUL_RUN) begin
         in_ready = 1'b0;
         busy     = 1'b1;
      end
   end

   assign result    = result_q;
   assign zero      = zero_q;
   assign out_valid = out_valid_q;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage datapath that consumes the 3-bit ALU control code from the ALU decoder and produces the stage result.
- AND/OR/ADD/SUB/SLT complete in one cycle.
- MUL runs as an iterative shift-add multiplier over WIDTH cycles; upstream is stalled through a valid/ready handshake.
- Sits between the ID/EX pipeline register and the EX/MEM register. Its busy indication drives the hazard unit's stall.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).
- CNT_W, $clog2(WIDTH), width of the multiply iteration counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous pipeline flush; aborts any in-flight operation.
- in_valid  input  1  operands and alu_control are valid this cycle.
- in_ready  output  1  unit can accept an operation this cycle.
- alu_control  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 101 MUL, 111 SLT.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B.
- result  output  WIDTH  registered result.
- zero  output  1  registered; 1 iff result==0.
- out_valid  output  1  one-cycle pulse; result/zero are new this cycle.
- busy  output  1  multiply in progress (equals ~in_ready).

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-low (rst_n); all state is updated only on rising clk.
- Reset values while rst_n=0: state IDLE, result=0, zero=1, out_valid=0, in_ready=1, busy=0, counter=0. Reset mid-multiply discards the operation with no out_valid.
- FSM: IDLE, MUL_RUN.
- IDLE:
  - in_ready=1.
  - Accept occurs when in_valid=1 and flush=0 at an edge.
  - Non-MUL accept: result <= f(src_a,src_b); zero <= (f==0); out_valid <= 1. Latency is 1 edge and back-to-back accepts are allowed every cycle.
  - MUL accept: latch mcand=src_a, mplr=src_b, acc=0, counter=WIDTH-1; go to MUL_RUN; out_valid <= 0; result unchanged.
  - No accept: out_valid <= 0; result and zero hold.
- MUL_RUN:
  - in_ready=0, busy=1.
  - Each edge: if mplr[0], acc += mcand (mod 2^WIDTH); mcand <<= 1; mplr >>= 1; counter -= 1.
  - On the edge where counter==0: result <= final acc; zero updates; out_valid <= 1; go to IDLE.
  - Fixed latency: out_valid is high in the cycle after edge WIDTH, counted from the accept edge. There is no early termination.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT is a signed compare; result = {WIDTH-1 zeros, (signed a < signed b)}.
  - MUL returns the low WIDTH bits of the product. Unsigned and signed low halves are identical, so no sign handling is required.
  - Unused codes 011 and 100 produce result=0, zero=1, out_valid=1 (treated as a single-cycle op).
- Handshake:
  - in_valid seen while in_ready=0 is ignored; upstream holds its operands under stall.
  - out_valid has no back-pressure; downstream always captures.
- flush:
  - Takes priority over in_valid and over MUL_RUN progress.
  - On an edge with flush=1: state <= IDLE, out_valid <= 0, result and zero hold, and the input that cycle is not accepted.
- Simultaneous events: rst_n=0 beats flush, which beats accept/iteration.
- in_ready is combinational from state only, never from in_valid.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and ADD 5+7. Required: result=0, zero=1, out_valid=0, in_ready=1 throughout. After release, ADD 5+7 gives result=12, zero=0, out_valid pulses 1 cycle later.
- Single-cycle ops back-to-back, one per cycle:
  - AND 0xF0F0_F0F0 & 0x0FF0_0FF0 → 0x00F0_00F0
  - OR → 0xFFF0_FFF0
  - SUB 3-3 → 0 with zero=1
  - SLT 0xFFFF_FFFF vs 1 → 1
  - ADD 0xFFFF_FFFF+1 → 0 with zero=1
  - Required: out_valid high on 5 consecutive cycles.
- MUL 1234×5678, WIDTH=32. Required: in_ready=0 for exactly 32 cycles; result=7006652 with out_valid pulse 32 cycles after accept. An ADD presented during busy is not accepted and completes (result 12) only after in_ready returns.
- MUL 0xFFFF_FFFF×0xFFFF_FFFF → result=1. MUL 0x8000_0000×2 → result=0, zero=1.
- Flush at iteration 10 of a MUL. Required: in_ready=1 next cycle, no out_valid, result holds its previous value. A subsequent ADD completes normally.
- Unused code 3'b011 with src_a=9, src_b=9 → result=0, zero=1, out_valid=1. A same-cycle flush with in_valid=1 → no accept, no out_valid.
